ip_sdram_arbiter: RTL

- Shares the single byte-wide port of ip_sdram (rd/wr/busy/address/wdata/rdata/rdata_en) between NUM_PORTS independent masters, e.g. debugger, CPU bridge and video fetch.
- Arbitration is round-robin with one command in flight at a time.
- Read data is steered back only to the master that issued the read.
- A read whose data never returns ends on a timeout with a defined value.

---
 rtl/ip_sdram_arbiter_pkg.sv | 16 +
 rtl/ip_sdram_rr_picker.sv | 26 ++
 rtl/ip_sdram_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ip_sdram_arbiter_pkg.sv
// Shared widths, FSM states and constants for the SDRAM port arbiter.
package ip_sdram_arbiter_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 8;
  localparam int TO_W   = 8;

  localparam logic [DATA_W-1:0] RDATA_TIMEOUT_VALUE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RD,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/ip_sdram_rr_picker.sv
// Combinational round-robin picker: first pending requester after rr_last.
module ip_sdram_rr_picker #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] pend,
  input  logic [IDX_W-1:0]     rr_last,
  output logic [IDX_W-1:0]     grant,
  output logic                 grant_valid
);

  // Walk offsets 1..NUM_PORTS from rr_last so the last winner is tried last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!grant_valid && pend[i] && (i == (int'(rr_last) + k) % NUM_PORTS)) begin
          grant       = IDX_W'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ip_sdram_arbiter.sv
// Round-robin arbiter sharing one byte-wide ip_sdram port between NUM_PORTS
// masters, one command in flight, with read-data steering and read timeout.
module ip_sdram_arbiter
  import ip_sdram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int RD_TIMEOUT = 63
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_rd,
  input  logic [NUM_PORTS-1:0]          req_wr,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_address,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          req_ack,
  output logic [DATA_W-1:0]             req_rdata,
  output logic [NUM_PORTS-1:0]          req_rdata_en,
  output logic                          rd_timeout,
  output logic                          sdram_rd,
  output logic                          sdram_wr,
  input  logic                          sdram_busy,
  output logic [ADDR_W-1:0]             sdram_address,
  output logic [DATA_W-1:0]             sdram_wdata,
  input  logic [DATA_W-1:0]             sdram_rdata,
  input  logic                          sdram_rdata_en
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_last_q, rr_last_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [TO_W-1:0]        cnt_q, cnt_d;
  logic                   sdram_rd_q, sdram_rd_d;
  logic                   sdram_wr_q, sdram_wr_d;
  logic [ADDR_W-1:0]      sdram_address_q, sdram_address_d;
  logic [DATA_W-1:0]      sdram_wdata_q, sdram_wdata_d;
  logic [NUM_PORTS-1:0]   req_ack_q, req_ack_d;
  logic [DATA_W-1:0]      req_rdata_q, req_rdata_d;
  logic [NUM_PORTS-1:0]   req_rdata_en_q, req_rdata_en_d;
  logic                   rd_timeout_q, rd_timeout_d;

  logic [NUM_PORTS-1:0]   pend;
  logic [IDX_W-1:0]       grant;
  logic                   grant_valid;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   sel_wr;

  assign pend = req_rd | req_wr;

  ip_sdram_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .pend        (pend),
    .rr_last     (rr_last_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Write wins over a simultaneous read from the same master.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_addr  = req_address[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wr    = req_wr[i];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_last_d       = rr_last_q;
    cur_d           = cur_q;
    cnt_d           = cnt_q;
    sdram_rd_d      = 1'b0;
    sdram_wr_d      = 1'b0;
    sdram_address_d = sdram_address_q;
    sdram_wdata_d   = sdram_wdata_q;
    req_ack_d       = '0;
    req_rdata_d     = req_rdata_q;
    req_rdata_en_d  = '0;
    rd_timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid && !sdram_busy) begin
          sdram_address_d = sel_addr;
          req_ack_d       = NUM_PORTS'(1) << grant;
          cur_d           = grant;
          rr_last_d       = grant;
          cnt_d           = '0;
          if (sel_wr) begin
            sdram_wr_d    = 1'b1;
            sdram_wdata_d = sel_wdata;
            state_d       = ST_HOLD;
          end else begin
            sdram_rd_d    = 1'b1;
            state_d       = ST_WAIT_RD;
          end
        end
      end

      // Returning data takes priority over a timeout on the same cycle.
      ST_WAIT_RD: begin
        if (sdram_rdata_en) begin
          req_rdata_d    = sdram_rdata;
          req_rdata_en_d = NUM_PORTS'(1) << cur_q;
          cnt_d          = '0;
          state_d        = ST_HOLD;
        end else if (cnt_q == TO_W'(RD_TIMEOUT - 1)) begin
          req_rdata_d    = RDATA_TIMEOUT_VALUE;
          req_rdata_en_d = NUM_PORTS'(1) << cur_q;
          rd_timeout_d   = 1'b1;
          cnt_d          = '0;
          state_d        = ST_HOLD;
        end else begin
          cnt_d          = cnt_q + TO_W'(1);
        end
      end

      ST_HOLD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      rr_last_q       <= IDX_W'(NUM_PORTS - 1);
      cur_q           <= '0;
      cnt_q           <= '0;
      sdram_rd_q      <= 1'b0;
      sdram_wr_q      <= 1'b0;
      sdram_address_q <= '0;
      sdram_wdata_q   <= '0;
      req_ack_q       <= '0;
      req_rdata_q     <= '0;
      req_rdata_en_q  <= '0;
      rd_timeout_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_last_q       <= rr_last_d;
      cur_q           <= cur_d;
      cnt_q           <= cnt_d;
      sdram_rd_q      <= sdram_rd_d;
      sdram_wr_q      <= sdram_wr_d;
      sdram_address_q <= sdram_address_d;
      sdram_wdata_q   <= sdram_wdata_d;
      req_ack_q       <= req_ack_d;
      req_rdata_q     <= req_rdata_d;
      req_rdata_en_q  <= req_rdata_en_d;
      rd_timeout_q    <= rd_timeout_d;
    end
  end

  assign sdram_rd      = sdram_rd_q;
  assign sdram_wr      = sdram_wr_q;
  assign sdram_address = sdram_address_q;
  assign sdram_wdata   = sdram_wdata_q;
  assign req_ack       = req_ack_q;
  assign req_rdata     = req_rdata_q;
  assign req_rdata_en  = req_rdata_en_q;
  assign rd_timeout    = rd_timeout_q;

endmodule
